// File: rtl/dice_pkg.sv
// Shared constants and types for the dice display: 7-segment patterns
// (active-high, g..a order), FSM state encoding and face width.
package dice_pkg;

    localparam int FACE_W = 3;

    localparam logic [6:0] SEG_BLANK  = 7'b0000000;
    localparam logic [6:0] SEG_DASH   = 7'b1000000;
    localparam logic [6:0] SEG_E      = 7'b1111001;
    localparam logic [6:0] SEG_FACE_1 = 7'b0000110;
    localparam logic [6:0] SEG_FACE_2 = 7'b1011011;
    localparam logic [6:0] SEG_FACE_3 = 7'b1001111;
    localparam logic [6:0] SEG_FACE_4 = 7'b1100110;
    localparam logic [6:0] SEG_FACE_5 = 7'b1101101;
    localparam logic [6:0] SEG_FACE_6 = 7'b1111101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ANIM = 2'd1,
        SHOW = 2'd2
    } state_t;

endpackage

// File: rtl/dice_display_if.sv
// Bundle between the dice controller (master) and the display (slave):
// rolled value/strobe in, segment drive and status out.
interface dice_display_if;
    import dice_pkg::*;

    logic [FACE_W-1:0] value;
    logic              rolled;
    logic [6:0]        seg;
    logic              dp;
    logic              busy;

    modport master (output value, rolled, input  seg, dp, busy);
    modport slave  (input  value, rolled, output seg, dp, busy);

endinterface

// File: rtl/seg7_dice_decoder.sv
// Combinational die value -> 7-segment pattern; 0 shows a dash, 7 shows E.
module seg7_dice_decoder
    import dice_pkg::*;
(
    input  logic [FACE_W-1:0] value,
    output logic [6:0]        seg
);

    always_comb begin
        seg = SEG_E;
        case (value)
            3'd0: seg = SEG_DASH;
            3'd1: seg = SEG_FACE_1;
            3'd2: seg = SEG_FACE_2;
            3'd3: seg = SEG_FACE_3;
            3'd4: seg = SEG_FACE_4;
            3'd5: seg = SEG_FACE_5;
            3'd6: seg = SEG_FACE_6;
            3'd7: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/dice_display.sv
// Dice display: tumbling, slowing face animation on each roll, then the rolled value.
// Optional DICE_DISPLAY_DP_BLINK_EN toggles dp at every animation step boundary.
module dice_display
    import dice_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int ANIM_STEPS = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    dice_display_if.slave bus
);

    localparam int CNT_W  = $clog2(TICK_DIV * ANIM_STEPS + 1);
    localparam int STEP_W = $clog2(ANIM_STEPS + 1);
    localparam logic [CNT_W-1:0]  DIV_C     = CNT_W'(TICK_DIV);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ANIM_STEPS - 1);

    state_t              state_reg, state_next;
    logic [FACE_W-1:0]   value_reg, value_next;
    logic [FACE_W-1:0]   face_reg,  face_next;
    logic [STEP_W-1:0]   step_reg,  step_next;
    logic [CNT_W-1:0]    tick_reg,  tick_next;
    logic [CNT_W-1:0]    len_reg,   len_next;
    logic [6:0]          seg_reg,   seg_next;
    logic                dp_reg,    dp_next;
    logic                busy_reg,  busy_next;
    logic                step_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            value_reg <= '0;
            face_reg  <= '0;
            step_reg  <= '0;
            tick_reg  <= '0;
            len_reg   <= '0;
            seg_reg   <= SEG_BLANK;
            dp_reg    <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            value_reg <= value_next;
            face_reg  <= face_next;
            step_reg  <= step_next;
            tick_reg  <= tick_next;
            len_reg   <= len_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
            busy_reg  <= busy_next;
        end
    end

    // Step length grows by TICK_DIV each step, so step k lasts TICK_DIV*(k+1) cycles.
    always_comb begin
        state_next = state_reg;
        value_next = value_reg;
        face_next  = face_reg;
        step_next  = step_reg;
        tick_next  = tick_reg;
        len_next   = len_reg;
        step_adv   = 1'b0;

        if (bus.rolled) begin
            value_next = bus.value;
            step_next  = '0;
            tick_next  = '0;
            len_next   = DIV_C;
            face_next  = FACE_W'(1);
            state_next = ANIM;
        end else if (state_reg == ANIM) begin
            if (tick_reg == len_reg - CNT_W'(1)) begin
                tick_next = '0;
                if (step_reg == LAST_STEP) begin
                    state_next = SHOW;
                end else begin
                    step_adv  = 1'b1;
                    step_next = step_reg + STEP_W'(1);
                    len_next  = len_reg + DIV_C;
                    face_next = (face_reg == FACE_W'(6)) ? FACE_W'(1) : face_reg + FACE_W'(1);
                end
            end else begin
                tick_next = tick_reg + CNT_W'(1);
            end
        end

        busy_next = (state_next == ANIM);

`ifdef DICE_DISPLAY_DP_BLINK_EN
        if (bus.rolled)
            dp_next = 1'b1;
        else if (state_next != ANIM)
            dp_next = 1'b0;
        else if (step_adv)
            dp_next = ~dp_reg;
        else
            dp_next = dp_reg;
`else
        dp_next = 1'b0;
`endif
    end

    // Decode the next face and next latched value so seg stays registered.
    logic [FACE_W-1:0] dec_in  [2];
    logic [6:0]        dec_out [2];

    assign dec_in[0] = face_next;
    assign dec_in[1] = value_next;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
        seg7_dice_decoder u_dec (
            .value (dec_in[gi]),
            .seg   (dec_out[gi])
        );
    end

    always_comb begin
        seg_next = SEG_BLANK;
        case (state_next)
            ANIM:    seg_next = dec_out[0];
            SHOW:    seg_next = dec_out[1];
            default: seg_next = SEG_BLANK;
        endcase
    end

    assign bus.seg  = seg_reg;
    assign bus.dp   = dp_reg;
    assign bus.busy = busy_reg;

endmodule

// File: tb/tb_dice_display.sv
// Directed bench for dice_display: two instances (TICK_DIV=2/ANIM_STEPS=3 and
// TICK_DIV=1/ANIM_STEPS=8) checked cycle by cycle against hand-written patterns.
module tb_dice_display;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dice_display_if if_a ();
    dice_display_if if_b ();

    dice_display #(.TICK_DIV(2), .ANIM_STEPS(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    dice_display #(.TICK_DIV(1), .ANIM_STEPS(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [6:0] face_pat [8];
    logic       dp_blink;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic get_out(input int which, output logic [6:0] seg, output logic busy, output logic dp);
        if (which == 0) begin
            seg = if_a.seg; busy = if_a.busy; dp = if_a.dp;
        end else begin
            seg = if_b.seg; busy = if_b.busy; dp = if_b.dp;
        end
    endtask

    // Called at a negedge: strobe is sampled at the next posedge (E0); returns
    // at the negedge of cycle E0 with value scrambled to prove it is latched.
    task automatic roll(input int which, input logic [2:0] v);
        if (which == 0) begin if_a.value = v; if_a.rolled = 1'b1; end
        else            begin if_b.value = v; if_b.rolled = 1'b1; end
        @(negedge clk);
        if (which == 0) begin if_a.rolled = 1'b0; if_a.value = ~v; end
        else            begin if_b.rolled = 1'b0; if_b.value = ~v; end
        $display("[TB] roll dut%0d value=%0d", which, v);
    endtask

    // Walks the animation one cycle at a time; stops after max_cycles checked cycles.
    task automatic watch_anim(input int which, input int tdiv, input int steps, input int max_cycles);
        logic [6:0] seg; logic busy; logic dp;
        int c = 0;
        for (int s = 0; s < steps; s++) begin
            for (int t = 0; t < tdiv * (s + 1); t++) begin
                if (c >= max_cycles) return;
                get_out(which, seg, busy, dp);
                check($sformatf("dut%0d c%0d s%0d seg", which, c, s), {1'b0, seg}, {1'b0, face_pat[(s % 6) + 1]});
                check($sformatf("dut%0d c%0d busy", which, c), {7'b0, busy}, 8'd1);
                check($sformatf("dut%0d c%0d dp", which, c), {7'b0, dp}, {7'b0, dp_blink & (s % 2 == 0)});
                c++;
                @(negedge clk);
            end
        end
    endtask

    task automatic check_show(input int which, input logic [6:0] exp, input int hold);
        logic [6:0] seg; logic busy; logic dp;
        for (int h = 0; h < hold; h++) begin
            get_out(which, seg, busy, dp);
            check($sformatf("dut%0d show%0d seg", which, h), {1'b0, seg}, {1'b0, exp});
            check($sformatf("dut%0d show%0d busy", which, h), {7'b0, busy}, 8'd0);
            check($sformatf("dut%0d show%0d dp", which, h), {7'b0, dp}, 8'd0);
            @(negedge clk);
        end
        $display("[TB] dut%0d settled seg=%b", which, exp);
    endtask

    initial begin
        face_pat[0] = 7'b0000000;
        face_pat[1] = 7'b0000110;
        face_pat[2] = 7'b1011011;
        face_pat[3] = 7'b1001111;
        face_pat[4] = 7'b1100110;
        face_pat[5] = 7'b1101101;
        face_pat[6] = 7'b1111101;
        face_pat[7] = 7'b0000000;
`ifdef DICE_DISPLAY_DP_BLINK_EN
        dp_blink = 1'b1;
`else
        dp_blink = 1'b0;
`endif
        if_a.value = 3'd0; if_a.rolled = 1'b0;
        if_b.value = 3'd0; if_b.rolled = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle after reset: blank, not busy, dp low.
        for (int i = 0; i < 50; i++) begin
            check($sformatf("idle c%0d seg", i), {1'b0, if_a.seg}, 8'd0);
            check($sformatf("idle c%0d busy", i), {7'b0, if_a.busy}, 8'd0);
            check($sformatf("idle c%0d dp", i), {7'b0, if_a.dp}, 8'd0);
            @(negedge clk);
        end
        check("idle b seg", {1'b0, if_b.seg}, 8'd0);
        $display("[TB] idle phase done");

        roll(0, 3'd4);
        watch_anim(0, 2, 3, 1000);
        check_show(0, 7'b1100110, 4);

        roll(1, 3'd5);
        watch_anim(1, 1, 8, 1000);
        check_show(1, 7'b1101101, 3);

        // Restart mid-animation: strobe sampled at E0+7 while showing face 3.
        roll(0, 3'd3);
        watch_anim(0, 2, 3, 6);
        check("pre-restart face3", {1'b0, if_a.seg}, {1'b0, face_pat[3]});
        roll(0, 3'd2);
        watch_anim(0, 2, 3, 1000);
        check_show(0, 7'b1011011, 3);

        roll(0, 3'd0);
        watch_anim(0, 2, 3, 1000);
        check_show(0, 7'b1000000, 2);

        roll(0, 3'd7);
        watch_anim(0, 2, 3, 1000);
        check_show(0, 7'b1111001, 2);

        // Asynchronous reset mid-animation.
        roll(0, 3'd6);
        watch_anim(0, 2, 3, 3);
        check("pre-reset busy", {7'b0, if_a.busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("async rst seg", {1'b0, if_a.seg}, 8'd0);
        check("async rst busy", {7'b0, if_a.busy}, 8'd0);
        check("async rst dp", {7'b0, if_a.dp}, 8'd0);
        check("async rst b seg", {1'b0, if_b.seg}, 8'd0);
        $display("[TB] async reset mid-animation");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post rst seg", {1'b0, if_a.seg}, 8'd0);
        check("post rst busy", {7'b0, if_a.busy}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
